// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - EX-stage ALU with iterative multiply/divide and HI/LO registers
// Optional signed MULT/DIV: define ALU_SIGNED_MULDIV_EN
module alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             div_zero
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  // opnd: multiplicand (MUL) or divisor (DIV); acc_hi/acc_lo: product halves or remainder/quotient
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic               div_unused;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

`ifdef ALU_SIGNED_MULDIV_EN
  // neg_q negates the product/quotient, neg_r the remainder, at the final iteration
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Operand magnitudes for the signed ops; the most-negative value maps to itself as unsigned
  always_comb begin
    abs_a = dataA[WIDTH-1] ? -dataA : dataA;
    abs_b = dataB[WIDTH-1] ? -dataB : dataB;
  end
`endif

  // One shift-add step and one restoring-divide step computed from the current accumulators
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = ~div_diff[WIDTH+1];
    rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {acc_lo[WIDTH-2:0], div_ok};
  end

  // The accepted remainder is always below the divisor, so its top trial bit carries nothing
  assign div_unused = div_diff[WIDTH] ^ div_shift[WIDTH];

  // Sign correction applied to the last-step results when committing to HI/LO
  always_comb begin
    prod_fix = mul_next;
    quo_fix  = quo_next;
    rem_fix  = rem_next;
`ifdef ALU_SIGNED_MULDIV_EN
    if (neg_q) begin
      prod_fix = -mul_next;
      quo_fix  = -quo_next;
    end
    if (neg_r) begin
      rem_fix = -rem_next;
    end
`endif
  end

  // Main control: single-cycle decode in IDLE, one iteration per cycle in MUL/DIV
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dataOut  <= '0;
      div_zero <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done <= 1'b1;
            case (Signal)
              F_ADD:  dataOut <= dataA + dataB;
              F_SUB:  dataOut <= dataA - dataB;
              F_AND:  dataOut <= dataA & dataB;
              F_OR:   dataOut <= dataA | dataB;
              F_SLT:  dataOut <= {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
              F_MFHI: dataOut <= hi;
              F_MFLO: dataOut <= lo;
              F_MULTU: begin
                done     <= 1'b0;
                busy     <= 1'b1;
                state    <= S_MUL;
                cnt      <= '0;
                opnd     <= dataA;
                acc_hi   <= '0;
                acc_lo   <= dataB;
                div_zero <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
                neg_q    <= 1'b0;
                neg_r    <= 1'b0;
`endif
              end
              F_DIVU: begin
                done     <= 1'b0;
                busy     <= 1'b1;
                state    <= S_DIV;
                cnt      <= '0;
                opnd     <= dataB;
                acc_hi   <= '0;
                acc_lo   <= dataA;
                div_zero <= (dataB == '0);
`ifdef ALU_SIGNED_MULDIV_EN
                neg_q    <= 1'b0;
                neg_r    <= 1'b0;
`endif
              end
`ifdef ALU_SIGNED_MULDIV_EN
              F_MULT: begin
                done     <= 1'b0;
                busy     <= 1'b1;
                state    <= S_MUL;
                cnt      <= '0;
                opnd     <= abs_a;
                acc_hi   <= '0;
                acc_lo   <= abs_b;
                div_zero <= 1'b0;
                neg_q    <= dataA[WIDTH-1] ^ dataB[WIDTH-1];
                neg_r    <= 1'b0;
              end
              F_DIV: begin
                done     <= 1'b0;
                busy     <= 1'b1;
                state    <= S_DIV;
                cnt      <= '0;
                opnd     <= abs_b;
                acc_hi   <= '0;
                acc_lo   <= abs_a;
                div_zero <= (dataB == '0);
                neg_q    <= dataA[WIDTH-1] ^ dataB[WIDTH-1];
                neg_r    <= dataA[WIDTH-1];
              end
`endif
              default: dataOut <= '0;
            endcase
          end
        end

        S_MUL: begin
          acc_hi <= mul_next[2*WIDTH-1:WIDTH];
          acc_lo <= mul_next[WIDTH-1:0];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            hi      <= prod_fix[2*WIDTH-1:WIDTH];
            lo      <= prod_fix[WIDTH-1:0];
            dataOut <= prod_fix[WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
          end
        end

        S_DIV: begin
          acc_hi <= rem_next;
          acc_lo <= quo_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Remainder of a zero divide is the dividend itself; only the quotient is forced
            hi      <= rem_fix;
            lo      <= div_zero ? '1 : quo_fix;
            dataOut <= div_zero ? '1 : quo_fix;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation ALU for the MIPS-style datapath.
- Keeps the existing funct-coded single-cycle ops: ADD, SUB, AND, OR, SLT.
- Adds an iterative unsigned multiply/divide unit with HI/LO registers, MFHI/MFLO readback, and a start/busy/done handshake.
- Sits in the EX stage; the control unit stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits (>=4); operands, result, HI and LO are WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  operation request; sampled only when busy=0
- Signal  input  6  funct code: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, MFHI 010000, MFLO 010010, MULTU 011001, DIVU 011011
- dataA  input  WIDTH  operand A (multiplicand / dividend)
- dataB  input  WIDTH  operand B (multiplier / divisor)
- busy  output  1  multi-cycle op in progress; start ignored
- done  output  1  one-cycle pulse: dataOut valid, op complete
- dataOut  output  WIDTH  registered result
- div_zero  output  1  sticky flag: last DIVU had dataB=0; cleared at next accepted DIVU or MULTU

Behaviour:
- Reset (async, any time including mid-operation): dataOut=0, HI=0, LO=0, busy=0, done=0, div_zero=0, counter=0, FSM=IDLE. No partial result survives.
- FSM states: IDLE, MUL, DIV.
  - IDLE: accepts start.
  - MUL / DIV: iterate; return to IDLE after WIDTH iterations.
- Acceptance: start=1 and busy=0 at edge E0. While busy=1, start is ignored and the op is dropped, not queued. done defaults to 0 every cycle.
- Single-cycle ops (ADD, SUB, AND, OR, SLT, MFHI, MFLO):
  - Result registered at E0; dataOut valid and done=1 for the cycle after E0.
  - busy stays 0. Back-to-back starts are allowed every cycle.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH; no overflow trap.
  - SLT is a signed two's-complement compare, result {0..0, A<B}.
  - MFHI/MFLO return HI/LO.
  - HI/LO are not modified by single-cycle ops.
- MULTU (shift-add, one partial-product bit per cycle):
  - FSM→MUL at E0; busy=1 from after E0 until edge E_WIDTH.
  - At E_WIDTH: {HI,LO} = dataA*dataB (2*WIDTH-bit unsigned product), busy=0, done=1 for one cycle, dataOut=LO.
  - Operands are latched at E0; input changes during busy have no effect.
- DIVU (restoring, one quotient bit per cycle):
  - Same timing as MULTU. At E_WIDTH: LO = quotient, HI = remainder, dataOut=LO.
  - dataB=0: no trap, same WIDTH-cycle timing; result LO = all ones, HI = dataA, div_zero=1.
- Unknown Signal with start=1: dataOut=0, done=1 next cycle, HI/LO unchanged, busy=0.
- Start in the same cycle that done pulses from a multi-cycle op: accepted, since busy=0 in that cycle.
- Outputs are stable between operations: dataOut holds its last value.

Optional Feature:
- Macro: ALU_SIGNED_MULDIV_EN.
- Defined:
  - Adds MULT 011000 and DIV 011010, signed two's-complement with the same WIDTH-cycle timing.
  - Implementation: operands are converted to magnitudes at E0; results are sign-corrected at E_WIDTH.
  - DIV quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed divide by zero: LO = all ones, HI = dataA, div_zero=1.
  - Most-negative / -1: LO = most-negative, HI = 0.
- Not defined: 011000 and 011010 are treated as unknown codes (dataOut=0, done after 1 cycle).

Test Plan (WIDTH=32):
- ADD 5+7, then SUB 3-5, then SLT FFFFFFFF vs 00000001 on consecutive cycles -> dataOut 0000000C, FFFFFFFE, 00000001 on consecutive cycles, each with done=1, busy=0 throughout.
- MULTU FFFFFFFF*00000002 -> busy for exactly 32 cycles, done pulse, dataOut=FFFFFFFE; then MFHI -> 00000001, MFLO -> FFFFFFFE.
- DIVU 100/7 -> after 32 cycles LO=0000000E, HI=00000002; DIVU 9/0 -> LO=FFFFFFFF, HI=00000009, div_zero=1; next MULTU clears div_zero.
- start DIVU, then pulse start with ADD at cycle 5 -> ADD ignored; DIVU result unaffected; no extra done pulse.
- Assert reset at cycle 10 of a MULTU -> busy, done, dataOut, HI, LO all 0 immediately (async); MFHI after release returns 0.
- With ALU_SIGNED_MULDIV_EN: MULT -3*5 -> HI=FFFFFFFF, LO=FFFFFFF1; DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. Without the macro: MULT -> dataOut=0 after 1 cycle.
